gmii2fifo_px: RTL and testbench
===============================

Name: gmii2fifo_px

Overview:
- Parametrised successor of the 24-bit GMII-to-FIFO receiver for the HDMI-over-Ethernet (hdmits) receive path.
- Parses the Ethernet/IPv4/UDP headers of each GMII frame (preamble included) and filters frames per channel ID.
- Unpacks the line-header payload (Y line, starting X) and emits one FIFO word per pixel, with an auto-incrementing X coordinate.
- Handles configurable pixel width, UDP-length-driven payload end, FIFO backpressure by packet drop, and drop statistics.

Parameters:
- IPV4_DST, {8'd192,8'd168,8'd0,8'd1}: base destination IP; accepted last octet = IPV4_DST[7:0] + id.
- DST_PORT, 16'd12345: accepted UDP destination port.
- ETH_TYPE, 16'h0800: accepted EtherType.
- IP_VERSION, 8'h45: accepted IPv4 version/IHL byte.
- IP_PROTO, 8'h11: accepted IP protocol.
- ID_W, 2: channel-ID width (2**ID_W channels).
- PIX_BYTES, 3: bytes per pixel; legal values 2 or 3.
- X_W, 12: X coordinate width.
- Y_W, 12: Y coordinate width.
- MAX_UDP_LEN, 16'd1472: largest accepted UDP length field.

Ports:
- clk125, in, 1: GMII receive clock.
- sys_rst_n, in, 1: asynchronous active-low reset.
- id, in, ID_W: channel selector, added to the destination-IP last octet.
- rxd, in, 8: GMII data.
- rx_dv, in, 1: GMII data valid.
- fifo_full, in, 1: downstream FIFO full.
- dout, out, X_W+Y_W+8*PIX_BYTES: {x, y, pixel}.
- wr_en, out, 1: one-cycle write strobe for dout.
- packet_en, out, 1: high while an accepted packet's pixels are streaming.
- pkt_ok, out, 1: one-cycle pulse when a packet completes cleanly.
- pkt_drop, out, 1: one-cycle pulse when an accepted packet is aborted.
- drop_cnt, out, 16: saturating count of pkt_drop pulses.

Behaviour:
- Reset is asynchronous, active-low: sys_rst_n low drives all state to IDLE and all outputs to 0 (dout, wr_en, packet_en, pkt_ok, pkt_drop, drop_cnt). This applies mid-packet; no partial word is written.
- Byte counter cnt (11 bit) increments on every rx_dv=1 cycle and saturates at 2047. rx_dv=0 clears cnt and captured fields and returns to IDLE next cycle.
- Captured header offsets (cnt):
  - 0x14-0x15: eth_type.
  - 0x16: ip_ver.
  - 0x1F: proto.
  - 0x26-0x29: ip_dst.
  - 0x2C-0x2D: dst_port.
  - 0x2E-0x2F: udp_len.
- States:
  - IDLE: rx_dv=1 -> HDR.
  - HDR: at cnt=0x32 (first payload byte), evaluate match. Match requires all captured fields equal, last octet = IPV4_DST[7:0]+id (8-bit wrap), and 11+PIX_BYTES <= udp_len <= MAX_UDP_LEN. Match -> capture y[7:0] and go to PHDR. No match -> IGNORE (no pulses, drop_cnt unchanged).
  - PHDR: cnt=0x33 captures {x[3:0], y[11:8]}; cnt=0x34 captures x[11:4]. Then PIXEL with packet_en=1. For Y_W/X_W > 12, upper bits are zero. For widths < 12, the low bits are taken.
  - PIXEL: bytes are shifted in MSB-first (first byte lands in pixel[8*PIX_BYTES-1 -: 8]). On the PIX_BYTES-th byte:
    - fifo_full=0: next cycle wr_en=1 with dout={x_cur, y, pixel}; x_cur then increments, wrapping mod 2**X_W.
    - fifo_full=1: no write; pkt_drop pulse, drop_cnt+1, go to IGNORE.
  - Payload end is cnt = 0x2A + udp_len (exclusive). At that byte boundary, go to DONE and pulse pkt_ok once. A trailing partial pixel (fewer than PIX_BYTES bytes) is discarded silently. FCS and padding bytes are ignored.
  - rx_dv falling while in PHDR or PIXEL before the payload end: pkt_drop pulse, drop_cnt+1. Words already written stand.
  - IGNORE and DONE: wait for rx_dv=0, then IDLE.
- Latency: wr_en asserts exactly 1 cycle after the final pixel byte is sampled.
- dout holds its value between writes.
- packet_en falls the cycle after DONE, IGNORE, or rx_dv loss.
- pkt_ok and pkt_drop never assert in the same cycle.
- drop_cnt saturates at 16'hFFFF.

Decomposition:
- Package gmii2fifo_pkg holds:
  - offset constants OFS_ETH_TYPE=0x14, OFS_IP_VER=0x16, OFS_PROTO=0x1F, OFS_IP_DST=0x26, OFS_DST_PORT=0x2C, OFS_UDP_LEN=0x2E, OFS_PAYLOAD=0x32, OFS_UDP_HDR=0x2A.
  - the state enum (IDLE, HDR, PHDR, PIXEL, IGNORE, DONE).
- One natural sub-module, gmii_hdr_capture, performs the offset-indexed field capture and match comparison. The top level keeps the FSM and pixel packer.

Test Plan:
- Matching frame, id=0, dst 192.168.0.1:12345, udp_len=8+3+9, PIX_BYTES=3, y=0x123, x=0x010, pixel bytes 0x11..0x99 -> three wr_en pulses:
  - dout = {0x010, 0x123, 0x112233}
  - dout = {0x011, 0x123, 0x445566}
  - dout = {0x012, 0x123, 0x778899}
  - then one pkt_ok pulse.
- Same frame with dst .1 and id=1 -> no wr_en, no pulses, drop_cnt stays 0. Resending to dst .2 -> accepted.
- fifo_full raised during the 2nd pixel -> exactly 1 write, pkt_drop pulse, drop_cnt=1, no pkt_ok.
- rx_dv dropped after 4 pixel bytes -> 1 write, pkt_drop pulse; the next valid frame decodes normally.
- PIX_BYTES=2, udp_len=8+3+5 -> two 16-bit pixels written, 5th byte ignored, pkt_ok pulse.
- sys_rst_n pulsed low mid-PIXEL -> all outputs 0 immediately. The next frame after release is fully received.

Source files
------------

// File: rtl/gmii2fifo_pkg.sv
// Shared constants and types for the GMII-to-FIFO pixel receiver.
// Offsets count GMII bytes from the first preamble byte of a frame.
package gmii2fifo_pkg;

    localparam logic [10:0] OFS_ETH_TYPE = 11'h014;
    localparam logic [10:0] OFS_IP_VER   = 11'h016;
    localparam logic [10:0] OFS_PROTO    = 11'h01F;
    localparam logic [10:0] OFS_IP_DST   = 11'h026;
    localparam logic [10:0] OFS_DST_PORT = 11'h02C;
    localparam logic [10:0] OFS_UDP_LEN  = 11'h02E;
    localparam logic [10:0] OFS_PAYLOAD  = 11'h032;
    localparam logic [10:0] OFS_UDP_HDR  = 11'h02A;
    localparam logic [10:0] CNT_MAX      = 11'h7FF;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PHDR,
        PIXEL,
        IGNORE,
        DONE
    } state_t;

endpackage

// File: rtl/gmii_hdr_capture.sv
// Captures Ethernet/IPv4/UDP header fields at fixed byte offsets and
// reports whether the frame is addressed to this channel.
module gmii_hdr_capture
    import gmii2fifo_pkg::*;
#(
    parameter logic [31:0] IPV4_DST    = {8'd192, 8'd168, 8'd0, 8'd1},
    parameter logic [15:0] DST_PORT    = 16'd12345,
    parameter logic [15:0] ETH_TYPE    = 16'h0800,
    parameter logic [7:0]  IP_VERSION  = 8'h45,
    parameter logic [7:0]  IP_PROTO    = 8'h11,
    parameter int          ID_W        = 2,
    parameter int          PIX_BYTES   = 3,
    parameter logic [15:0] MAX_UDP_LEN = 16'd1472
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      rxd,
    input  logic            rx_dv,
    input  logic [10:0]     cnt,
    input  logic [ID_W-1:0] id,
    output logic            hdr_match,
    output logic [15:0]     udp_len
);

    // Smallest payload that still carries the 3-byte line header plus one pixel.
    localparam logic [15:0] MIN_UDP_LEN = 16'(11 + PIX_BYTES);

    logic [15:0] eth_type;
    logic [7:0]  ip_ver;
    logic [7:0]  proto;
    logic [31:0] ip_dst;
    logic [15:0] dst_port;
    logic [7:0]  dst_octet;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eth_type <= '0;
            ip_ver   <= '0;
            proto    <= '0;
            ip_dst   <= '0;
            dst_port <= '0;
            udp_len  <= '0;
        end else if (!rx_dv) begin
            eth_type <= '0;
            ip_ver   <= '0;
            proto    <= '0;
            ip_dst   <= '0;
            dst_port <= '0;
            udp_len  <= '0;
        end else begin
            case (cnt)
                OFS_ETH_TYPE:         eth_type[15:8] <= rxd;
                OFS_ETH_TYPE + 11'd1: eth_type[7:0]  <= rxd;
                OFS_IP_VER:           ip_ver         <= rxd;
                OFS_PROTO:            proto          <= rxd;
                OFS_IP_DST:           ip_dst[31:24]  <= rxd;
                OFS_IP_DST + 11'd1:   ip_dst[23:16]  <= rxd;
                OFS_IP_DST + 11'd2:   ip_dst[15:8]   <= rxd;
                OFS_IP_DST + 11'd3:   ip_dst[7:0]    <= rxd;
                OFS_DST_PORT:         dst_port[15:8] <= rxd;
                OFS_DST_PORT + 11'd1: dst_port[7:0]  <= rxd;
                OFS_UDP_LEN:          udp_len[15:8]  <= rxd;
                OFS_UDP_LEN + 11'd1:  udp_len[7:0]   <= rxd;
                default: ;
            endcase
        end
    end

    assign dst_octet = IPV4_DST[7:0] + 8'(id);

    assign hdr_match = (eth_type == ETH_TYPE)
                    && (ip_ver == IP_VERSION)
                    && (proto == IP_PROTO)
                    && (ip_dst[31:8] == IPV4_DST[31:8])
                    && (ip_dst[7:0] == dst_octet)
                    && (dst_port == DST_PORT)
                    && (udp_len >= MIN_UDP_LEN)
                    && (udp_len <= MAX_UDP_LEN);

endmodule

// File: rtl/gmii2fifo_px.sv
// GMII receiver for the hdmits path: filters UDP line packets by channel
// and writes one {x, y, pixel} FIFO word per received pixel.
module gmii2fifo_px
    import gmii2fifo_pkg::*;
#(
    parameter logic [31:0] IPV4_DST    = {8'd192, 8'd168, 8'd0, 8'd1},
    parameter logic [15:0] DST_PORT    = 16'd12345,
    parameter logic [15:0] ETH_TYPE    = 16'h0800,
    parameter logic [7:0]  IP_VERSION  = 8'h45,
    parameter logic [7:0]  IP_PROTO    = 8'h11,
    parameter int          ID_W        = 2,
    parameter int          PIX_BYTES   = 3,
    parameter int          X_W         = 12,
    parameter int          Y_W         = 12,
    parameter logic [15:0] MAX_UDP_LEN = 16'd1472
) (
    input  logic                           clk125,
    input  logic                           sys_rst_n,
    input  logic [ID_W-1:0]                id,
    input  logic [7:0]                     rxd,
    input  logic                           rx_dv,
    input  logic                           fifo_full,
    output logic [X_W+Y_W+8*PIX_BYTES-1:0] dout,
    output logic                           wr_en,
    output logic                           packet_en,
    output logic                           pkt_ok,
    output logic                           pkt_drop,
    output logic [15:0]                    drop_cnt
);

    localparam int          PW       = 8 * PIX_BYTES;
    localparam logic [1:0]  PIX_LAST = 2'(PIX_BYTES - 1);

    state_t          state;
    state_t          state_nx;
    logic [10:0]     cnt;
    logic            hdr_match;
    logic [15:0]     udp_len;
    logic [15:0]     pay_last;
    logic            at_last;
    logic [1:0]      pcnt;
    logic            pix_last;
    logic [PW-1:0]   pixel;
    logic [PW-1:0]   pixel_nx;
    logic [7:0]      y_lo;
    logic [3:0]      x_lo;
    logic [Y_W-1:0]  y;
    logic [X_W-1:0]  x_cur;
    logic            cap_ylo;
    logic            cap_yhi;
    logic            cap_xhi;
    logic            shift_en;
    logic            wr_nx;
    logic            ok_nx;
    logic            drop_nx;

    gmii_hdr_capture #(
        .IPV4_DST    (IPV4_DST),
        .DST_PORT    (DST_PORT),
        .ETH_TYPE    (ETH_TYPE),
        .IP_VERSION  (IP_VERSION),
        .IP_PROTO    (IP_PROTO),
        .ID_W        (ID_W),
        .PIX_BYTES   (PIX_BYTES),
        .MAX_UDP_LEN (MAX_UDP_LEN)
    ) u_hdr (
        .clk       (clk125),
        .rst_n     (sys_rst_n),
        .rxd       (rxd),
        .rx_dv     (rx_dv),
        .cnt       (cnt),
        .id        (id),
        .hdr_match (hdr_match),
        .udp_len   (udp_len)
    );

    always_ff @(posedge clk125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (!rx_dv) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 11'd1;
        end
    end

    // Index of the last payload byte; UDP length counts from the UDP header.
    assign pay_last = udp_len + 16'(OFS_UDP_HDR) - 16'd1;
    assign at_last  = ({5'd0, cnt} == pay_last);
    assign pix_last = (pcnt == PIX_LAST);
    assign pixel_nx = {pixel[PW-9:0], rxd};

    always_ff @(posedge clk125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        cap_ylo  = 1'b0;
        cap_yhi  = 1'b0;
        cap_xhi  = 1'b0;
        shift_en = 1'b0;
        wr_nx    = 1'b0;
        ok_nx    = 1'b0;
        drop_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_dv) state_nx = HDR;
            end
            HDR: begin
                if (!rx_dv) begin
                    state_nx = IDLE;
                end else if (cnt == OFS_PAYLOAD) begin
                    if (hdr_match) begin
                        cap_ylo  = 1'b1;
                        state_nx = PHDR;
                    end else begin
                        state_nx = IGNORE;
                    end
                end
            end
            PHDR: begin
                if (!rx_dv) begin
                    drop_nx  = 1'b1;
                    state_nx = IDLE;
                end else if (cnt == OFS_PAYLOAD + 11'd1) begin
                    cap_yhi = 1'b1;
                end else if (cnt == OFS_PAYLOAD + 11'd2) begin
                    cap_xhi  = 1'b1;
                    state_nx = PIXEL;
                end
            end
            PIXEL: begin
                if (!rx_dv) begin
                    drop_nx  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    shift_en = 1'b1;
                    // A full FIFO at a pixel boundary aborts the whole line.
                    if (pix_last && fifo_full) begin
                        drop_nx  = 1'b1;
                        state_nx = IGNORE;
                    end else begin
                        wr_nx = pix_last;
                        if (at_last) begin
                            ok_nx    = 1'b1;
                            state_nx = DONE;
                        end
                    end
                end
            end
            IGNORE, DONE: begin
                if (!rx_dv) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_en    <= 1'b0;
            pkt_ok   <= 1'b0;
            pkt_drop <= 1'b0;
            drop_cnt <= '0;
            dout     <= '0;
        end else begin
            wr_en    <= wr_nx;
            pkt_ok   <= ok_nx;
            pkt_drop <= drop_nx;
            if (drop_nx && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (wr_nx) dout <= {x_cur, y, pixel_nx};
        end
    end

    always_ff @(posedge clk125 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            y_lo  <= '0;
            x_lo  <= '0;
            y     <= '0;
            x_cur <= '0;
            pcnt  <= '0;
            pixel <= '0;
        end else begin
            if (cap_ylo) y_lo <= rxd;
            if (cap_yhi) begin
                y    <= Y_W'({rxd[3:0], y_lo});
                x_lo <= rxd[7:4];
            end
            if (cap_xhi) begin
                x_cur <= X_W'({rxd, x_lo});
                pcnt  <= '0;
            end
            if (shift_en) begin
                pixel <= pixel_nx;
                pcnt  <= pix_last ? 2'd0 : pcnt + 2'd1;
            end
            if (wr_nx) x_cur <= x_cur + X_W'(1);
        end
    end

    assign packet_en = (state == PIXEL);

endmodule

// File: tb/tb_gmii2fifo_px.sv
// Scoreboard bench: one 3-byte-pixel and one 2-byte-pixel receiver fed with
// generated GMII frames; expected words are queued as each frame is built.
module tb_gmii2fifo_px;

    logic        clk125 = 1'b0;
    logic        sys_rst_n;
    logic [1:0]  id;
    logic [7:0]  rxd;
    logic        rx_dv;
    logic        fifo_full;
    int          lane;
    logic        dv0, dv1;

    logic [47:0] dout0;
    logic        wr_en0, packet_en0, pkt_ok0, pkt_drop0;
    logic [15:0] drop_cnt0;
    logic [39:0] dout1;
    logic        wr_en1, packet_en1, pkt_ok1, pkt_drop1;
    logic [15:0] drop_cnt1;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q0[$];
    logic [63:0] exp_q1[$];
    int wr_cnt[2], ok_cnt[2], dp_cnt[2];
    int exp_wr[2], exp_ok[2], exp_dp[2], exp_dc[2];

    always #4 clk125 = ~clk125;

    assign dv0 = rx_dv && (lane == 0);
    assign dv1 = rx_dv && (lane == 1);

    gmii2fifo_px dut0 (
        .clk125 (clk125), .sys_rst_n (sys_rst_n), .id (id), .rxd (rxd),
        .rx_dv (dv0), .fifo_full (fifo_full), .dout (dout0), .wr_en (wr_en0),
        .packet_en (packet_en0), .pkt_ok (pkt_ok0), .pkt_drop (pkt_drop0),
        .drop_cnt (drop_cnt0)
    );

    gmii2fifo_px #(.PIX_BYTES(2)) dut1 (
        .clk125 (clk125), .sys_rst_n (sys_rst_n), .id (id), .rxd (rxd),
        .rx_dv (dv1), .fifo_full (fifo_full), .dout (dout1), .wr_en (wr_en1),
        .packet_en (packet_en1), .pkt_ok (pkt_ok1), .pkt_drop (pkt_drop1),
        .drop_cnt (drop_cnt1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pb(input int i);
        return 8'((i + 1) * 17);
    endfunction

    always @(negedge clk125) begin
        if (wr_en0) begin
            wr_cnt[0]++;
            if (exp_q0.size() > 0) check("dout0", 64'(dout0), exp_q0.pop_front());
        end
        if (wr_en1) begin
            wr_cnt[1]++;
            if (exp_q1.size() > 0) check("dout1", 64'(dout1), exp_q1.pop_front());
        end
        if (pkt_ok0) ok_cnt[0]++;
        if (pkt_drop0) dp_cnt[0]++;
        if (pkt_ok1) ok_cnt[1]++;
        if (pkt_drop1) dp_cnt[1]++;
        if (pkt_ok0 || pkt_drop0) check("ok_drop_excl0", 64'(pkt_ok0 & pkt_drop0), 64'd0);
        if (pkt_ok1 || pkt_drop1) check("ok_drop_excl1", 64'(pkt_ok1 & pkt_drop1), 64'd0);
    end

    task automatic drive(input logic [7:0] b);
        rxd   = b;
        rx_dv = 1'b1;
        @(posedge clk125);
        #1;
    endtask

    // full_at / cut_at / rst_at are pixel-byte indices, -1 disables each.
    task automatic send(input int ln, input logic [7:0] oct, input logic [15:0] ulen,
                        input logic [11:0] y, input logic [11:0] x,
                        input int full_at, input int cut_at, input int rst_at);
        logic [7:0]  hdr[$];
        logic [15:0] tl;
        logic [11:0] xk;
        logic [63:0] w;
        int  p, npb, j;
        bit  acc, drop_e, ok_e, stopped;
        lane    = ln;
        p       = (ln == 0) ? 3 : 2;
        acc     = (oct == 8'(1 + id)) && (ulen >= 16'(11 + p)) && (ulen <= 16'd1472);
        npb     = int'(ulen) - 11;
        if (npb < 0) npb = 0;
        drop_e  = 1'b0;
        ok_e    = 1'b0;
        stopped = 1'b0;
        for (int k = 0; k * p + p - 1 < npb; k++) begin
            j = k * p + p - 1;
            if (cut_at >= 0 && j >= cut_at) break;
            if (rst_at >= 0 && j >= rst_at - 1) break;
            if (full_at >= 0 && j >= full_at) begin
                drop_e = 1'b1;
                break;
            end
            xk = x + 12'(k);
            if (p == 3) w = {16'd0, xk, y, pb(j - 2), pb(j - 1), pb(j)};
            else        w = {24'd0, xk, y, pb(j - 1), pb(j)};
            if (acc) begin
                if (ln == 0) exp_q0.push_back(w);
                else         exp_q1.push_back(w);
                exp_wr[ln]++;
            end
        end
        if (cut_at >= 0 && cut_at < npb) drop_e = 1'b1;
        if (rst_at >= 0) drop_e = 1'b0;
        ok_e = !drop_e && (rst_at < 0) && (cut_at < 0 || cut_at >= npb);
        if (acc) begin
            exp_ok[ln] += int'(ok_e);
            exp_dp[ln] += int'(drop_e);
            if (drop_e && exp_dc[ln] < 65535) exp_dc[ln]++;
        end

        tl = ulen + 16'd20;
        for (int i = 0; i < 7; i++) hdr.push_back(8'h55);
        hdr.push_back(8'hD5);
        for (int i = 0; i < 6; i++) hdr.push_back(8'h02);
        for (int i = 0; i < 6; i++) hdr.push_back(8'h04);
        hdr.push_back(8'h08); hdr.push_back(8'h00);
        hdr.push_back(8'h45); hdr.push_back(8'h00); hdr.push_back(tl[15:8]); hdr.push_back(tl[7:0]);
        hdr.push_back(8'h00); hdr.push_back(8'h00); hdr.push_back(8'h40); hdr.push_back(8'h00);
        hdr.push_back(8'h40); hdr.push_back(8'h11); hdr.push_back(8'h00); hdr.push_back(8'h00);
        hdr.push_back(8'd192); hdr.push_back(8'd168); hdr.push_back(8'd0); hdr.push_back(8'd100);
        hdr.push_back(8'd192); hdr.push_back(8'd168); hdr.push_back(8'd0); hdr.push_back(oct);
        hdr.push_back(8'h30); hdr.push_back(8'h39); hdr.push_back(8'h30); hdr.push_back(8'h39);
        hdr.push_back(ulen[15:8]); hdr.push_back(ulen[7:0]); hdr.push_back(8'h00); hdr.push_back(8'h00);
        hdr.push_back(y[7:0]); hdr.push_back({x[3:0], y[11:8]}); hdr.push_back(x[11:4]);
        foreach (hdr[i]) drive(hdr[i]);

        for (int i = 0; i < npb; i++) begin
            if (i == cut_at) begin
                stopped = 1'b1;
                break;
            end
            if (i == rst_at) begin
                sys_rst_n = 1'b0;
                #1;
                check("rst_dout", 64'(dout0), 64'd0);
                check("rst_wr_en", 64'(wr_en0), 64'd0);
                check("rst_packet_en", 64'(packet_en0), 64'd0);
                check("rst_pkt_ok", 64'(pkt_ok0), 64'd0);
                check("rst_pkt_drop", 64'(pkt_drop0), 64'd0);
                check("rst_drop_cnt", 64'(drop_cnt0), 64'd0);
                @(posedge clk125);
                #1;
                rx_dv     = 1'b0;
                sys_rst_n = 1'b1;
                exp_dc[0] = 0;
                exp_dc[1] = 0;
                stopped   = 1'b1;
                break;
            end
            fifo_full = (full_at >= 0 && i >= full_at);
            if (i == 1) check("packet_en", 64'(ln == 0 ? packet_en0 : packet_en1), 64'(acc));
            drive(pb(i));
        end
        if (!stopped) for (int i = 0; i < 4; i++) drive(8'hA5);
        rx_dv     = 1'b0;
        fifo_full = 1'b0;
        repeat (10) @(posedge clk125);
        #1;
        check("wr_count", 64'(wr_cnt[ln]), 64'(exp_wr[ln]));
        check("ok_count", 64'(ok_cnt[ln]), 64'(exp_ok[ln]));
        check("drop_pulses", 64'(dp_cnt[ln]), 64'(exp_dp[ln]));
        check("drop_cnt", 64'(ln == 0 ? drop_cnt0 : drop_cnt1), 64'(exp_dc[ln]));
    endtask

    initial begin
        sys_rst_n = 1'b0;
        id        = 2'd0;
        rxd       = 8'h00;
        rx_dv     = 1'b0;
        fifo_full = 1'b0;
        lane      = 0;
        for (int i = 0; i < 2; i++) begin
            wr_cnt[i] = 0; ok_cnt[i] = 0; dp_cnt[i] = 0;
            exp_wr[i] = 0; exp_ok[i] = 0; exp_dp[i] = 0; exp_dc[i] = 0;
        end
        repeat (3) @(posedge clk125);
        #1;
        check("reset_dout0", 64'(dout0), 64'd0);
        check("reset_wr_en0", 64'(wr_en0), 64'd0);
        check("reset_packet_en0", 64'(packet_en0), 64'd0);
        check("reset_pkt_ok0", 64'(pkt_ok0), 64'd0);
        check("reset_pkt_drop0", 64'(pkt_drop0), 64'd0);
        check("reset_drop_cnt0", 64'(drop_cnt0), 64'd0);
        check("reset_dout1", 64'(dout1), 64'd0);
        sys_rst_n = 1'b1;
        @(posedge clk125);
        #1;

        // Clean 3-pixel line, then the channel filter on id.
        send(0, 8'd1, 16'd20, 12'h123, 12'h010, -1, -1, -1);
        id = 2'd1;
        send(0, 8'd1, 16'd20, 12'h123, 12'h010, -1, -1, -1);
        send(0, 8'd2, 16'd20, 12'h456, 12'h7FE, -1, -1, -1);
        id = 2'd0;
        // Length limits: one below the minimum and one above the maximum.
        send(0, 8'd1, 16'd13, 12'h001, 12'h000, -1, -1, -1);
        send(0, 8'd1, 16'd1473, 12'h001, 12'h000, -1, -1, -1);
        // Backpressure and early rx_dv loss, then recovery.
        send(0, 8'd1, 16'd20, 12'h0A0, 12'h020, 3, -1, -1);
        send(0, 8'd1, 16'd20, 12'h0B0, 12'h030, -1, 4, -1);
        send(0, 8'd1, 16'd23, 12'hFFF, 12'hFFE, -1, -1, -1);
        // 2-byte pixels with a trailing partial pixel.
        send(1, 8'd1, 16'd16, 12'h321, 12'h100, -1, -1, -1);
        // Asynchronous reset mid-line, then a normal line.
        send(0, 8'd1, 16'd20, 12'h055, 12'h066, -1, -1, 4);
        send(0, 8'd1, 16'd20, 12'h123, 12'h010, -1, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
